// File: rtl/timing_check_monitor.sv
// timing_check_monitor: synthesisable multi-channel setup/hold window checker.
// Each channel measures data/reference event spacing in clk cycles and logs violations.
module timing_check_monitor #(
  parameter int CHANNELS  = 4,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         data_i,
  input  logic [CHANNELS-1:0]         ref_i,
  input  logic [CHANNELS-1:0]         cond_i,
  input  logic [2*CHANNELS-1:0]       data_edge_i,
  input  logic [2*CHANNELS-1:0]       ref_edge_i,
  input  logic                        clr_i,
  output logic [CHANNELS-1:0]         setup_viol_o,
  output logic [CHANNELS-1:0]         hold_viol_o,
  output logic [CHANNELS-1:0]         notifier_o,
  output logic [CHANNELS*CNT_W-1:0]   viol_cnt_o,
  output logic [CHANNELS-1:0]         sticky_o,
  output logic                        irq_o
);

  localparam int MAXD = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int DW   = (MAXD < 2) ? 1 : $clog2(MAXD + 1);
  localparam logic [DW-1:0] MAXD_L  = DW'(MAXD);
  localparam logic [DW-1:0] SETUP_L = DW'(SETUP_CYC);
  localparam logic [DW-1:0] HOLD_L  = DW'(HOLD_CYC);

  // Sampled inputs: *_smp_r holds the value taken at the latest edge, *_prv_r the one before.
  logic [CHANNELS-1:0]       data_smp_r;
  logic [CHANNELS-1:0]       data_prv_r;
  logic [CHANNELS-1:0]       ref_smp_r;
  logic [CHANNELS-1:0]       ref_prv_r;
  logic [CHANNELS-1:0]       cond_smp_r;
  logic [2*CHANNELS-1:0]     dsel_smp_r;
  logic [2*CHANNELS-1:0]     rsel_smp_r;
  logic                      prime_r;
  logic                      evt_vld_r;

  logic [DW-1:0]             d_cnt_r [CHANNELS];
  logic [DW-1:0]             r_cnt_r [CHANNELS];
  logic [DW-1:0]             d_nxt_s [CHANNELS];
  logic [DW-1:0]             r_nxt_s [CHANNELS];

  logic [CHANNELS-1:0]       d_evt_s;
  logic [CHANNELS-1:0]       r_evt_s;
  logic [CHANNELS-1:0]       setup_s;
  logic [CHANNELS-1:0]       hold_s;
  logic [CHANNELS-1:0]       viol_s;

  logic [CHANNELS*CNT_W-1:0] cnt_r;
  logic [CHANNELS*CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0]          cnt_base_s;
  logic [CHANNELS-1:0]       sticky_r;
  logic [CHANNELS-1:0]       sticky_nxt_s;
  logic [CHANNELS-1:0]       setup_r;
  logic [CHANNELS-1:0]       hold_r;
  logic [CHANNELS-1:0]       notifier_r;
  logic                      irq_r;

  function automatic logic edge_hit(input logic prv, input logic cur, input logic [1:0] sel);
    logic hit;
    case (sel)
      2'b01:   hit = ~prv & cur;
      2'b10:   hit = prv & ~cur;
      2'b11:   hit = prv ^ cur;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Event detection and distance update; a coincident pair resolves to setup first.
  always_comb begin
    d_evt_s = {CHANNELS{1'b0}};
    r_evt_s = {CHANNELS{1'b0}};
    setup_s = {CHANNELS{1'b0}};
    hold_s  = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      d_nxt_s[c] = MAXD_L;
      r_nxt_s[c] = MAXD_L;
      if (evt_vld_r) begin
        d_evt_s[c] = edge_hit(data_prv_r[c], data_smp_r[c], dsel_smp_r[2*c +: 2]) & cond_smp_r[c];
        r_evt_s[c] = edge_hit(ref_prv_r[c], ref_smp_r[c], rsel_smp_r[2*c +: 2]);
      end else begin
        d_evt_s[c] = 1'b0;
        r_evt_s[c] = 1'b0;
      end
      if (d_evt_s[c]) begin
        d_nxt_s[c] = {DW{1'b0}};
      end else if (d_cnt_r[c] >= MAXD_L) begin
        d_nxt_s[c] = MAXD_L;
      end else begin
        d_nxt_s[c] = d_cnt_r[c] + DW'(1);
      end
      if (r_evt_s[c]) begin
        r_nxt_s[c] = {DW{1'b0}};
      end else if (r_cnt_r[c] >= MAXD_L) begin
        r_nxt_s[c] = MAXD_L;
      end else begin
        r_nxt_s[c] = r_cnt_r[c] + DW'(1);
      end
      setup_s[c] = r_evt_s[c] & (d_nxt_s[c] < SETUP_L);
      hold_s[c]  = d_evt_s[c] & ~setup_s[c] & (r_nxt_s[c] < HOLD_L);
    end
  end

  assign viol_s = setup_s | hold_s;

  // Counter and sticky next state; a violation landing with clr_i still records.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    cnt_base_s   = {CNT_W{1'b0}};
    sticky_nxt_s = clr_i ? viol_s : (sticky_r | viol_s);
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_base_s = clr_i ? {CNT_W{1'b0}} : cnt_r[c*CNT_W +: CNT_W];
      if (viol_s[c] && !(&cnt_base_s)) begin
        cnt_nxt_s[c*CNT_W +: CNT_W] = cnt_base_s + CNT_W'(1);
      end else begin
        cnt_nxt_s[c*CNT_W +: CNT_W] = cnt_base_s;
      end
    end
  end

  // Sampling pipeline and priming: events become valid from the second edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_smp_r <= {CHANNELS{1'b0}};
      data_prv_r <= {CHANNELS{1'b0}};
      ref_smp_r  <= {CHANNELS{1'b0}};
      ref_prv_r  <= {CHANNELS{1'b0}};
      cond_smp_r <= {CHANNELS{1'b0}};
      dsel_smp_r <= {(2*CHANNELS){1'b0}};
      rsel_smp_r <= {(2*CHANNELS){1'b0}};
      prime_r    <= 1'b0;
      evt_vld_r  <= 1'b0;
    end else begin
      data_smp_r <= data_i;
      data_prv_r <= data_smp_r;
      ref_smp_r  <= ref_i;
      ref_prv_r  <= ref_smp_r;
      cond_smp_r <= cond_i;
      dsel_smp_r <= data_edge_i;
      rsel_smp_r <= ref_edge_i;
      prime_r    <= 1'b1;
      evt_vld_r  <= prime_r;
    end
  end

  // Distance counters and violation bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        d_cnt_r[c] <= MAXD_L;
        r_cnt_r[c] <= MAXD_L;
      end
      setup_r    <= {CHANNELS{1'b0}};
      hold_r     <= {CHANNELS{1'b0}};
      notifier_r <= {CHANNELS{1'b0}};
      cnt_r      <= {(CHANNELS*CNT_W){1'b0}};
      sticky_r   <= {CHANNELS{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        d_cnt_r[c] <= d_nxt_s[c];
        r_cnt_r[c] <= r_nxt_s[c];
      end
      setup_r    <= setup_s;
      hold_r     <= hold_s;
      notifier_r <= notifier_r ^ viol_s;
      cnt_r      <= cnt_nxt_s;
      sticky_r   <= sticky_nxt_s;
      irq_r      <= |sticky_r;
    end
  end

  assign setup_viol_o = setup_r;
  assign hold_viol_o  = hold_r;
  assign notifier_o   = notifier_r;
  assign viol_cnt_o   = cnt_r;
  assign sticky_o     = sticky_r;
  assign irq_o        = irq_r;

endmodule

// File: tb/tb_timing_check_monitor.sv
// Self-checking bench for timing_check_monitor: directed scenarios then random traffic,
// compared against an edge-indexed reference model of the setup/hold rules.
module tb_timing_check_monitor;
  localparam int CH    = 4;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   data_i, ref_i, cond_i;
  logic [2*CH-1:0] data_edge_i, ref_edge_i;
  logic            clr_i;
  logic [CH-1:0]   setup_viol_o, hold_viol_o, notifier_o, sticky_o;
  logic [CH*CW-1:0] viol_cnt_o;
  logic            irq_o;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: absolute edge numbers of the last events per channel.
  int            edge_no;
  logic [CH-1:0] pd, pr;
  int            last_d [CH];
  int            last_r [CH];
  logic [CH-1:0] pend_s, pend_h;
  logic [CH-1:0] exp_setup, exp_hold, exp_not, exp_sticky;
  logic          exp_irq;
  int            exp_cnt [CH];

  always #5 clk = ~clk;

  timing_check_monitor #(
    .CHANNELS(CH), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .ref_i(ref_i), .cond_i(cond_i),
    .data_edge_i(data_edge_i), .ref_edge_i(ref_edge_i), .clr_i(clr_i),
    .setup_viol_o(setup_viol_o), .hold_viol_o(hold_viol_o), .notifier_o(notifier_o),
    .viol_cnt_o(viol_cnt_o), .sticky_o(sticky_o), .irq_o(irq_o)
  );

  function automatic logic hit(input logic p, input logic v, input logic [1:0] s);
    return (s[0] & ~p & v) | (s[1] & p & ~v);
  endfunction

  task automatic model_reset();
    edge_no = 0;
    pd = '0; pr = '0; pend_s = '0; pend_h = '0;
    exp_setup = '0; exp_hold = '0; exp_not = '0; exp_sticky = '0; exp_irq = 1'b0;
    for (int c = 0; c < CH; c++) begin
      last_d[c] = -1000; last_r[c] = -1000; exp_cnt[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic de, re, s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_irq = |exp_sticky;
    for (int c = 0; c < CH; c++) begin
      if (clr_i) begin
        exp_cnt[c] = 0; exp_sticky[c] = 1'b0;
      end
      if (pend_s[c] || pend_h[c]) begin
        exp_cnt[c] = (exp_cnt[c] < CMAX) ? exp_cnt[c] + 1 : CMAX;
        exp_sticky[c] = 1'b1;
        exp_not[c] = ~exp_not[c];
      end
    end
    exp_setup = pend_s; exp_hold = pend_h;
    pend_s = '0; pend_h = '0;
    edge_no++;
    if (edge_no >= 2) begin
      for (int c = 0; c < CH; c++) begin
        de = hit(pd[c], data_i[c], data_edge_i[2*c +: 2]) & cond_i[c];
        re = hit(pr[c], ref_i[c], ref_edge_i[2*c +: 2]);
        if (de) last_d[c] = edge_no;
        if (re) last_r[c] = edge_no;
        s = re && ((edge_no - last_d[c]) < SETUP);
        pend_s[c] = s;
        pend_h[c] = de && !s && ((edge_no - last_r[c]) < HOLD);
      end
    end
    pd = data_i; pr = ref_i;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [CH*CW-1:0] ecnt;
    for (int c = 0; c < CH; c++) ecnt[c*CW +: CW] = CW'(exp_cnt[c]);
    chk("setup_viol_o", 64'(setup_viol_o), 64'(exp_setup));
    chk("hold_viol_o",  64'(hold_viol_o),  64'(exp_hold));
    chk("notifier_o",   64'(notifier_o),   64'(exp_not));
    chk("viol_cnt_o",   64'(viol_cnt_o),   64'(ecnt));
    chk("sticky_o",     64'(sticky_o),     64'(exp_sticky));
    chk("irq_o",        64'(irq_o),        64'(exp_irq));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; clr_i = 1'b0;
    data_i = '0; ref_i = '0; cond_i = '1;
    data_edge_i = 8'b0000_0001; ref_edge_i = 8'b0000_0001;
    tick(); tick();
    chk("reset_cnt", 64'(viol_cnt_o), 64'h0);
    rst_n = 1'b1;

    // 1: data rise at edge 10, ref rise at edge 11 -> setup pulse after edge 12
    repeat (9) tick();
    data_i[0] = 1'b1; tick();
    ref_i[0] = 1'b1;  tick();
    tick();
    chk("t1_setup", 64'(setup_viol_o), 64'h1);
    chk("t1_cnt0",  64'(viol_cnt_o[1:0]), 64'h1);
    chk("t1_notif", 64'(notifier_o[0]), 64'h1);
    chk("t1_irq_lag", 64'(irq_o), 64'h0);
    tick();
    chk("t1_irq", 64'(irq_o), 64'h1);
    chk("t1_pulse_end", 64'(setup_viol_o), 64'h0);
    data_i[0] = 1'b0; ref_i[0] = 1'b0;
    repeat (4) tick();
    data_i[0] = 1'b1; tick();
    tick();
    ref_i[0] = 1'b1;  tick();
    tick(); tick();
    chk("t1_two_edges_ok", 64'(viol_cnt_o[1:0]), 64'h1);

    // 2: hold with falling data select, then same case gated by cond
    data_edge_i[1:0] = 2'b10;
    ref_i[0] = 1'b0; repeat (4) tick();
    ref_i[0] = 1'b1; tick();
    data_i[0] = 1'b0; tick();
    tick();
    chk("t2_hold", 64'(hold_viol_o), 64'h1);
    chk("t2_no_setup", 64'(setup_viol_o), 64'h0);
    data_i[0] = 1'b1; ref_i[0] = 1'b0; repeat (4) tick();
    ref_i[0] = 1'b1; tick();
    data_i[0] = 1'b0; cond_i[0] = 1'b0; tick();
    cond_i[0] = 1'b1; tick();
    chk("t2_cond_gate", 64'(hold_viol_o), 64'h0);
    tick();

    // 3: coincident rise counts once as setup
    data_edge_i[1:0] = 2'b01;
    ref_i[0] = 1'b0; repeat (4) tick();
    data_i[0] = 1'b1; ref_i[0] = 1'b1; tick();
    tick();
    chk("t3_setup", 64'(setup_viol_o), 64'h1);
    chk("t3_no_hold", 64'(hold_viol_o), 64'h0);
    tick();

    // 4: five violations on channel 1 with a 2-bit counter
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    data_edge_i[3:2] = 2'b11; ref_edge_i[3:2] = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      data_i[1] = ~data_i[1]; ref_i[1] = ~ref_i[1];
      tick();
      if (i > 0) chk("t4_cnt_seq", 64'(viol_cnt_o[3:2]), 64'((i < 3) ? i : 3));
    end
    tick();
    chk("t4_cnt_sat", 64'(viol_cnt_o[3:2]), 64'h3);
    chk("t4_notif",   64'(notifier_o[1]), 64'h1);
    chk("t4_ch0_cnt", 64'(viol_cnt_o[1:0]), 64'h0);

    // 5: clear coinciding with a recorded violation, then clear alone
    data_edge_i[5:4] = 2'b01; ref_edge_i[5:4] = 2'b01;
    tick();
    data_i[2] = 1'b1; ref_i[2] = 1'b1; tick();
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("t5_cnt2", 64'(viol_cnt_o[5:4]), 64'h1);
    chk("t5_sticky", 64'(sticky_o), 64'h4);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("t5_clr_cnt", 64'(viol_cnt_o), 64'h0);
    chk("t5_clr_sticky", 64'(sticky_o), 64'h0);
    chk("t5_irq_lag", 64'(irq_o), 64'h1);
    tick();
    chk("t5_irq_drop", 64'(irq_o), 64'h0);

    // 6: data high across reset release, then reset inside a setup window
    rst_n = 1'b0; data_i = 4'b0001; ref_i = '0;
    tick(); tick();
    rst_n = 1'b1; tick();
    ref_i[0] = 1'b1; tick();
    tick(); tick();
    chk("t6_no_spurious", 64'(setup_viol_o | hold_viol_o), 64'h0);
    chk("t6_cnt", 64'(viol_cnt_o), 64'h0);
    data_i[0] = 1'b0; ref_i[0] = 1'b0; repeat (3) tick();
    data_i[0] = 1'b1; tick();
    rst_n = 1'b0; #1;
    model_reset();
    check_outputs();
    rst_n = 1'b1; ref_i[0] = 1'b1;
    tick(); tick(); tick();
    chk("t6_reset_window", 64'(viol_cnt_o), 64'h0);
    chk("t6_sticky", 64'(sticky_o), 64'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_n  = ($urandom_range(0, 149) != 0);
      data_i = data_i ^ (4'($urandom) & 4'($urandom));
      ref_i  = ref_i ^ (4'($urandom) & 4'($urandom));
      cond_i = ~(4'($urandom) & 4'($urandom) & 4'($urandom));
      clr_i  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 31) == 0) data_edge_i = 8'($urandom);
      if ($urandom_range(0, 31) == 0) ref_edge_i = 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/timing_check_monitor.md
Name: timing_check_monitor

Overview:
- Synthesisable, multi-channel runtime equivalent of the simulation-only $setup/$hold timing checks.
- Each channel watches one data signal against one reference signal, both already synchronous to clk.
- Flags setup and hold window violations measured in clk cycles, with per-channel edge selection and a condition gate (the &&& analogue).
- Toggles a per-channel notifier, keeps saturating violation counters, and raises a sticky interrupt. Sits beside the debug/status register block.

Parameters:
CHANNELS, 4, number of independent check channels (1..32)
SETUP_CYC, 2, minimum cycles from data event to reference event (0 disables setup check)
HOLD_CYC, 2, minimum cycles from reference event to data event (0 disables hold check)
CNT_W, 8, width of each per-channel violation counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
data_i  in  CHANNELS  monitored data signals
ref_i  in  CHANNELS  reference signals
cond_i  in  CHANNELS  condition gate; a data event is ignored when its cond bit is 0 in the same cycle
data_edge_i  in  2*CHANNELS  per-channel data edge select: 00 none, 01 rise (01), 10 fall (10), 11 any
ref_edge_i  in  2*CHANNELS  per-channel reference edge select, same encoding
clr_i  in  1  synchronous clear of counters and sticky flags
setup_viol_o  out  CHANNELS  one-cycle setup violation pulse
hold_viol_o  out  CHANNELS  one-cycle hold violation pulse
notifier_o  out  CHANNELS  toggles on every violation of that channel
viol_cnt_o  out  CHANNELS*CNT_W  saturating violation count; channel c occupies bits [c*CNT_W +: CNT_W]
sticky_o  out  CHANNELS  set on violation, cleared only by clr_i or reset
irq_o  out  1  OR of sticky_o, registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0, all counters 0.
  - Previous-value registers 0; prime flag cleared.
  - Cycle-distance counters set to saturated ("no recent event").
- Priming:
  - On the first clk edge after reset release, previous-value registers load data_i/ref_i; no events are generated.
  - Events are detected from the second edge onward. An input already high at reset release never produces a spurious rise.
- Event detection (per channel, at edge N):
  - Compare the sampled input with the previous sample.
  - Event = the transition matches the 2-bit select.
  - Data event additionally requires cond_i[c]=1 at edge N.
- Distance counters:
  - d_cnt counts edges since the last data event; r_cnt counts edges since the last reference event.
  - Each is reset to 0 on its event and otherwise increments, saturating at max(SETUP_CYC,HOLD_CYC).
- Setup violation: a reference event at edge N while d_cnt < SETUP_CYC, i.e. the data event was fewer than SETUP_CYC edges earlier.
- Hold violation: a data event at edge N while r_cnt < HOLD_CYC.
- Coincident data and reference events at the same edge (distance 0):
  - Counted once, as setup if SETUP_CYC>=1.
  - Otherwise counted as hold if HOLD_CYC>=1.
  - Otherwise no violation.
  - A channel never asserts setup and hold in the same cycle.
- Latency: violation outputs are registered and asserted for exactly one cycle, after edge N+1 where N is the detection edge. notifier_o, viol_cnt_o and sticky_o update on the same edge.
- Counter:
  - Increments by 1 per violation and saturates at 2^CNT_W-1; no wrap.
  - Channels are fully independent.
- clr_i:
  - Clears all counters and sticky bits at the edge it is sampled.
  - A violation updating at that same edge is still recorded, giving count=1 and sticky=1.
  - clr_i does not affect notifier_o or the distance counters.
- irq_o lags sticky_o by one cycle.
- Select 00 disables that event source entirely. Changing a select mid-run takes effect on the next edge; distance counters are not reset.
- Reset asserted mid-window discards all pending distance state; after re-priming, no violation is reported from events that preceded the reset.

Test Plan:
1. SETUP_CYC=2, sel rise/rise: data_i[0] rises at edge 10, ref_i[0] rises at edge 11 -> setup_viol_o[0] high for one cycle after edge 12, viol_cnt[0]=1, notifier_o[0]=1, irq_o=1 after edge 13. Repeat with ref at edge 12 -> no violation.
2. HOLD_CYC=2: ref rises at edge 20, data falls at edge 21 with data sel 10 -> hold_viol_o[0] pulse after edge 22. Same case with cond_i[0]=0 at edge 21 -> no violation.
3. Coincident rise of data and ref at edge 30 -> only setup_viol_o pulses; count +1, not +2.
4. CNT_W=2: force 5 setup violations on channel 1 -> viol_cnt[1] sequence 1,2,3,3,3; notifier_o[1] toggles 5 times (ends at 1); channel 0 count stays 0.
5. clr_i at the same edge a violation is recorded -> count=1, sticky=1. clr_i alone -> count=0, sticky=0, irq_o drops the next cycle.
6. data_i held high through reset release, then ref rises 1 edge later -> no violation. Reset pulsed between a data rise and a ref rise 1 edge apart -> no violation reported.
